// File: rtl/enemy_fire_scheduler_if.sv
// Handshake bundle between the enemy AI / bullet-slot array (master) and the
// fire scheduler (slave).
interface enemy_fire_scheduler_if #(
  parameter int NUM_SLOTS = 4,
  parameter int HIT_W     = 4
);
  logic                 fire_req;
  logic                 defend;
  logic                 hit_clr;
  logic [NUM_SLOTS-1:0] slot_busy;
  logic [NUM_SLOTS-1:0] slot_hit;
  logic [NUM_SLOTS-1:0] slot_attack;
  logic                 fire_ack;
  logic                 busy;
  logic [2:0]           shots_left;
  logic [HIT_W-1:0]     hit_count;
  logic                 player_hit;

  modport master (
    output fire_req, defend, hit_clr, slot_busy, slot_hit,
    input  slot_attack, fire_ack, busy, shots_left, hit_count, player_hit
  );

  modport slave (
    input  fire_req, defend, hit_clr, slot_busy, slot_hit,
    output slot_attack, fire_ack, busy, shots_left, hit_count, player_hit
  );
endinterface

// File: rtl/enemy_fire_scheduler.sv
// Turns enemy fire requests into bursts of one-hot attack strobes to free bullet
// slots, with gap/cooldown/defend sequencing and a saturating player-hit counter.
module enemy_fire_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int BURST_LEN = 3,
  parameter int BURST_GAP = 8,
  parameter int COOLDOWN  = 30,
  parameter int HIT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  enemy_fire_scheduler_if.slave bus
);

  localparam int TMAX = (BURST_GAP > COOLDOWN) ? BURST_GAP : COOLDOWN;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(NUM_SLOTS + 1);
  localparam int SW   = ((HIT_W > PW) ? HIT_W : PW) + 1;

  localparam logic [SW-1:0] SAT       = SW'((1 << HIT_W) - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(BURST_GAP - 1);
  localparam logic [TW-1:0] COOL_LOAD = TW'(COOLDOWN - 1);
  localparam logic [2:0]    SHOTS_INI = 3'(BURST_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_COOL  = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [TW-1:0]        r_timer;
  logic [TW-1:0]        w_timer_nxt;
  logic [2:0]           r_shots;
  logic [2:0]           w_shots_nxt;
  logic [HIT_W-1:0]     r_hit_count;
  logic                 r_player_hit;

  logic [NUM_SLOTS-1:0] w_free;
  logic [NUM_SLOTS-1:0] w_pick;
  logic                 w_any_free;
  logic                 w_accept;
  logic                 w_strobe;
  logic [SW-1:0]        w_pop;
  logic [SW-1:0]        w_sum;

  // Lowest free slot: isolate the least significant set bit of the free mask.
  assign w_free     = ~bus.slot_busy;
  assign w_pick     = w_free & (~w_free + NUM_SLOTS'(1));
  assign w_any_free = |w_free;

  // Qualified with rst_n so nothing leaks out while reset is held.
  assign w_accept = rst_n && (r_state == S_IDLE) && bus.fire_req && !bus.defend;
  assign w_strobe = rst_n && (r_state == S_ISSUE) && !bus.defend && w_any_free;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_shots_nxt = r_shots;
    case (r_state)
      S_IDLE: begin
        if (bus.fire_req && !bus.defend) begin
          w_state_nxt = S_ISSUE;
          w_shots_nxt = SHOTS_INI;
        end
      end
      S_ISSUE: begin
        if (bus.defend) begin
          w_state_nxt = S_COOL;
          w_timer_nxt = COOL_LOAD;
          w_shots_nxt = '0;
        end else if (w_any_free) begin
          w_shots_nxt = r_shots - 3'd1;
          if (r_shots > 3'd1) begin
            w_state_nxt = S_GAP;
            w_timer_nxt = GAP_LOAD;
          end else begin
            w_state_nxt = S_COOL;
            w_timer_nxt = COOL_LOAD;
          end
        end
      end
      S_GAP: begin
        if (bus.defend) begin
          w_state_nxt = S_COOL;
          w_timer_nxt = COOL_LOAD;
          w_shots_nxt = '0;
        end else if (r_timer == '0) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: begin
        if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_shots <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_shots <= w_shots_nxt;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      w_pop = w_pop + SW'(bus.slot_hit[i]);
    end
  end

  // Sum is computed one bit wider than the counter so saturation is a plain compare.
  assign w_sum = SW'(r_hit_count) + w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_player_hit <= 1'b0;
    end else begin
      r_player_hit <= |bus.slot_hit;
      if (bus.hit_clr) begin
        r_hit_count <= '0;
      end else if (w_sum > SAT) begin
        r_hit_count <= SAT[HIT_W-1:0];
      end else begin
        r_hit_count <= w_sum[HIT_W-1:0];
      end
    end
  end

  assign bus.slot_attack = w_strobe ? w_pick : '0;
  assign bus.fire_ack    = w_accept;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.shots_left  = r_shots;
  assign bus.hit_count   = r_hit_count;
  assign bus.player_hit  = r_player_hit;

  a_attack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.slot_attack));
  a_attack_free_only: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.slot_attack & bus.slot_busy) == '0);

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Scoreboard bench for enemy_fire_scheduler: a burst-level reference model fills
// expected-event queues per segment; a negedge monitor pops them as the DUT emits.
module tb_enemy_fire_scheduler;

  localparam int NS   = 4;
  localparam int BL   = 3;
  localparam int BG   = 8;
  localparam int CD   = 30;
  localparam int HW   = 4;
  localparam int MAXL = 320;

  typedef struct {
    int          cyc;
    logic [NS-1:0] vec;
    logic [2:0]  left;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic [HW-1:0] cnt;
  } hit_t;

  logic clk;
  logic rst_n;

  enemy_fire_scheduler_if #(.NUM_SLOTS(NS), .HIT_W(HW)) bus ();

  enemy_fire_scheduler #(
    .NUM_SLOTS(NS),
    .BURST_LEN(BL),
    .BURST_GAP(BG),
    .COOLDOWN (CD),
    .HIT_W    (HW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          s_fire [MAXL];
  logic          s_def  [MAXL];
  logic          s_clr  [MAXL];
  logic [NS-1:0] s_busy [MAXL];
  logic [NS-1:0] s_hit  [MAXL];

  logic          e_busy   [MAXL];
  logic [2:0]    e_left   [MAXL];
  logic          e_lknown [MAXL];
  logic          chg_v    [MAXL];
  logic [2:0]    chg_val  [MAXL];
  logic          chg_kn   [MAXL];

  int      q_ack[$];
  strobe_t q_str[$];
  hit_t    q_hit[$];

  int cyc;
  bit seg_active;
  int n_pass;
  int n_total;

  int      m_ack;
  strobe_t m_str;
  hit_t    m_hit;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic mark(input int c, input int L);
    if (c < L) e_busy[c] = 1'b1;
  endtask

  task automatic set_left(input int c, input int v, input bit kn, input int L);
    if (c < L) begin
      chg_v[c]   = 1'b1;
      chg_val[c] = 3'(v);
      chg_kn[c]  = kn;
    end
  endtask

  // Burst-level walk over the pre-generated stimulus timeline.
  task automatic model_segment(input int L);
    int t, end_t, shots, d, k;
    bit done;
    logic [2:0] cur;
    bit kn;
    strobe_t e;
    for (int c = 0; c < L; c++) begin
      e_busy[c] = 1'b0;
      chg_v[c]  = 1'b0;
    end
    t = 0;
    while (t < L) begin
      if (!s_fire[t] || s_def[t]) begin
        t++;
        continue;
      end
      q_ack.push_back(t);
      set_left(t + 1, BL, 1'b1, L);
      t++;
      shots = BL;
      done  = 1'b0;
      end_t = L;
      while (!done) begin
        while (t < L && !s_def[t] && s_busy[t] == '1) begin
          mark(t, L);
          t++;
        end
        if (t >= L) begin
          end_t = L;
          done  = 1'b1;
        end else begin
          mark(t, L);
          if (s_def[t]) begin
            end_t = t;
            set_left(t + 1, 0, 1'b0, L);
            done = 1'b1;
          end else begin
            k = 0;
            while (s_busy[t][k]) k++;
            e.cyc  = t;
            e.vec  = NS'(1) << k;
            e.left = 3'(shots);
            q_str.push_back(e);
            shots--;
            set_left(t + 1, shots, 1'b1, L);
            if (shots == 0) begin
              end_t = t;
              done  = 1'b1;
            end else begin
              d = -1;
              for (int g = 1; g <= BG && d < 0; g++) begin
                mark(t + g, L);
                if (t + g < L && s_def[t + g]) d = t + g;
              end
              if (d >= 0) begin
                end_t = d;
                set_left(d + 1, 0, 1'b1, L);
                done = 1'b1;
              end else begin
                t = t + BG + 1;
              end
            end
          end
        end
      end
      for (int c = end_t + 1; c <= end_t + CD; c++) mark(c, L);
      t = end_t + CD + 1;
    end
    cur = 3'd0;
    kn  = 1'b1;
    for (int c = 0; c < L; c++) begin
      if (chg_v[c]) begin
        cur = chg_val[c];
        kn  = chg_kn[c];
      end
      e_left[c]   = cur;
      e_lknown[c] = kn;
    end
  endtask

  task automatic model_hits(input int L);
    int cnt;
    hit_t h;
    cnt = 0;
    for (int c = 0; c < L; c++) begin
      if (s_clr[c]) cnt = 0;
      else begin
        cnt = cnt + $countones(s_hit[c]);
        if (cnt > (1 << HW) - 1) cnt = (1 << HW) - 1;
      end
      if (|s_hit[c] && c + 1 < L) begin
        h.cyc = c + 1;
        h.cnt = HW'(cnt);
        q_hit.push_back(h);
      end
    end
  endtask

  task automatic clear_stim(input int L);
    for (int c = 0; c < L; c++) begin
      s_fire[c] = 1'b0;
      s_def[c]  = 1'b0;
      s_clr[c]  = 1'b0;
      s_busy[c] = '0;
      s_hit[c]  = '0;
    end
  endtask

  task automatic fill_random(input int L, input int p_fire, input int p_def, input int p_busy);
    for (int c = 0; c < L; c++) begin
      s_fire[c] = ($urandom_range(99) < p_fire);
      s_def[c]  = ($urandom_range(99) < p_def);
      s_clr[c]  = ($urandom_range(99) < 3);
      for (int b = 0; b < NS; b++) begin
        s_busy[c][b] = ($urandom_range(99) < p_busy);
        s_hit[c][b]  = ($urandom_range(99) < 8);
      end
    end
  endtask

  task automatic zero_inputs();
    bus.fire_req  = 1'b0;
    bus.defend    = 1'b0;
    bus.hit_clr   = 1'b0;
    bus.slot_busy = '0;
    bus.slot_hit  = '0;
  endtask

  // Runs L cycles out of reset, then asserts reset mid-cycle with the last
  // inputs still applied and checks that every output drops at once.
  task automatic run_segment(input int L, input int pre_busy);
    model_segment(L);
    model_hits(L);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < L; c++) begin
      @(posedge clk);
      #1;
      cyc           = c;
      seg_active    = 1'b1;
      bus.fire_req  = s_fire[c];
      bus.defend    = s_def[c];
      bus.hit_clr   = s_clr[c];
      bus.slot_busy = s_busy[c];
      bus.slot_hit  = s_hit[c];
    end
    @(posedge clk);
    #1;
    seg_active = 1'b0;
    cyc        = L;
    if (pre_busy >= 0) chk("busy before reset", bus.busy, pre_busy);
    #2 rst_n = 1'b0;
    #1;
    chk("reset slot_attack", bus.slot_attack, 0);
    chk("reset fire_ack", bus.fire_ack, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset shots_left", bus.shots_left, 0);
    chk("reset hit_count", bus.hit_count, 0);
    chk("reset player_hit", bus.player_hit, 0);
    zero_inputs();
    chk("missing fire_ack events", q_ack.size(), 0);
    chk("missing strobe events", q_str.size(), 0);
    chk("missing player_hit events", q_hit.size(), 0);
    q_ack.delete();
    q_str.delete();
    q_hit.delete();
  endtask

  always @(negedge clk) begin
    if (seg_active) begin
      chk("busy", bus.busy, e_busy[cyc]);
      if (e_lknown[cyc]) chk("shots_left", bus.shots_left, e_left[cyc]);
      if (bus.fire_ack) begin
        chk("fire_ack expected", q_ack.size() > 0, 1);
        if (q_ack.size() > 0) begin
          m_ack = q_ack.pop_front();
          chk("fire_ack cycle", cyc, m_ack);
        end
      end
      if (bus.slot_attack != '0) begin
        chk("strobe expected", q_str.size() > 0, 1);
        if (q_str.size() > 0) begin
          m_str = q_str.pop_front();
          chk("strobe cycle", cyc, m_str.cyc);
          chk("strobe slot", bus.slot_attack, m_str.vec);
          chk("strobe shots_left", bus.shots_left, m_str.left);
        end
      end
      if (bus.player_hit) begin
        chk("player_hit expected", q_hit.size() > 0, 1);
        if (q_hit.size() > 0) begin
          m_hit = q_hit.pop_front();
          chk("player_hit cycle", cyc, m_hit.cyc);
          chk("hit_count", bus.hit_count, m_hit.cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass     = 0;
    n_total    = 0;
    cyc        = 0;
    seg_active = 1'b0;
    rst_n      = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);

    // Single-cycle request, all slots free: full burst then cooldown.
    clear_stim(55);
    s_fire[0] = 1'b1;
    run_segment(55, 0);

    // Lowest-free selection and stall while every slot is busy.
    clear_stim(30);
    s_fire[0] = 1'b1;
    s_busy[1] = 4'b0011;
    for (int c = 10; c < 15; c++) s_busy[c] = 4'b1111;
    for (int c = 15; c < 30; c++) s_busy[c] = 4'b1011;
    run_segment(30, 1);

    // Defend during the first gap aborts the burst.
    clear_stim(45);
    s_fire[0] = 1'b1;
    s_def[4]  = 1'b1;
    run_segment(45, 0);

    // Request blocked by defend in IDLE; request held through cooldown ignored.
    clear_stim(60);
    for (int c = 0; c < 3; c++) begin
      s_fire[c] = 1'b1;
      s_def[c]  = 1'b1;
    end
    s_fire[3] = 1'b1;
    for (int c = 25; c <= 50; c++) s_fire[c] = 1'b1;
    run_segment(60, 0);

    // Hit accounting: saturation at 15 and clear priority.
    clear_stim(12);
    for (int c = 0; c < 3; c++) s_hit[c] = 4'b1111;
    s_hit[3] = 4'b0011;
    s_hit[4] = 4'b1011;
    s_clr[6] = 1'b1;
    s_hit[6] = 4'b1111;
    s_hit[7] = 4'b1011;
    s_clr[8] = 1'b1;
    s_hit[9] = 4'b0001;
    run_segment(12, 0);

    // Reset lands mid-gap; the next request must start a full burst.
    clear_stim(5);
    s_fire[0] = 1'b1;
    run_segment(5, 1);
    clear_stim(25);
    s_fire[0] = 1'b1;
    run_segment(25, 1);

    for (int s = 0; s < 8; s++) begin
      fill_random(300, 10 + 5 * s, (s % 4) * 3, 40 + 8 * (s % 3));
      run_segment(300, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
